// File: rtl/bfloat_mantissa_div.sv
// bfloat_mantissa_div: sequential radix-2 restoring divider for bfloat mantissas.
// Divides the dividend {a, 7'b0} by b over 16 iterations. The quotient lines up
// with the 16-bit product format of the Booth mantissa multiplier.
// It also returns the 9-bit remainder and a divide-by-zero flag.
// Optional feature: define BFDIV_ROUND_EN to round the quotient to nearest at completion.
module bfloat_mantissa_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  a,
  input  logic [8:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic [8:0]  rem,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] dvd_q;      // dividend, shifted out MSB first
  logic [8:0]  dvs_q;      // captured divisor
  logic [9:0]  pr_q;       // partial remainder
  logic [15:0] quo_q;      // quotient shift register
  logic        bz_q;       // divisor was zero at capture
  logic [15:0] out_q;
  logic [8:0]  rem_q;
  logic        dz_q;

  logic        capture;
  logic        last_iter;
  logic [10:0] pr_shift;
  logic        ge;
  logic [9:0]  pr_next;
  logic [15:0] quo_next;
  logic [15:0] quo_final;

  assign capture   = start && (state_q == IDLE || state_q == DONE);
  assign last_iter = (state_q == RUN) && (cnt_q == 4'd15);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is ignored while running
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 4'd15) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded purely from registered state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // One restoring step. The 11-bit shifted value keeps the comparison exact.
  // When the subtract is taken the difference fits in 10 bits, because the
  // shifted value is below 2*b.
  always_comb begin
    pr_shift = {pr_q, dvd_q[15]};
    ge       = (pr_shift >= {2'b00, dvs_q});
    pr_next  = ge ? (pr_shift[9:0] - {1'b0, dvs_q}) : pr_shift[9:0];
    quo_next = {quo_q[14:0], ge};
  end

  // Final quotient: truncated, or rounded to nearest with saturation
  always_comb begin
`ifdef BFDIV_ROUND_EN
    if (({pr_next[8:0], 1'b0} >= {1'b0, dvs_q}) && (quo_next != 16'hFFFF))
      quo_final = quo_next + 16'd1;
    else
      quo_final = quo_next;
`else
    quo_final = quo_next;
`endif
  end

  // Datapath: operand capture, iteration, and result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
      dvd_q <= 16'h0000;
      dvs_q <= 9'h000;
      pr_q  <= 10'h000;
      quo_q <= 16'h0000;
      bz_q  <= 1'b0;
      out_q <= 16'h0000;
      rem_q <= 9'h000;
      dz_q  <= 1'b0;
    end else if (capture) begin
      cnt_q <= 4'd0;
      dvd_q <= {a, 7'b0};
      dvs_q <= b;
      pr_q  <= 10'h000;
      quo_q <= 16'h0000;
      bz_q  <= (b == 9'h000);
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 4'd1;
      dvd_q <= {dvd_q[14:0], 1'b0};
      pr_q  <= pr_next;
      quo_q <= quo_next;
      if (last_iter) begin
        if (bz_q) begin
          out_q <= 16'hFFFF;
          rem_q <= 9'h000;
          dz_q  <= 1'b1;
        end else begin
          out_q <= quo_final;
          rem_q <= pr_next[8:0];
          dz_q  <= 1'b0;
        end
      end
    end
  end

  assign out = out_q;
  assign rem = rem_q;
  assign dz  = dz_q;

endmodule

// File: tb/tb_bfloat_mantissa_div.sv
// Directed testbench for bfloat_mantissa_div with hand-computed expectations.
module tb_bfloat_mantissa_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  a;
  logic [8:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [8:0]  rem;
  logic        dz;

  int errors = 0;
  int checks = 0;

  bfloat_mantissa_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .rem   (rem),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start for one edge with the given operands
  task automatic start_div(input logic [8:0] av, input logic [8:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = 9'h1AA;  // scribble inputs; they must not matter during RUN
    b     = 9'h055;
  endtask

  // Count edges until done rises, with a bounded wait
  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (!done && edges < 40) begin
      if (busy) busy_n++;
      step();
      edges++;
    end
  endtask

  // Full transaction: start, wait, check latency/busy/results, then one idle edge
  task automatic run_div(input string tag, input logic [8:0] av, input logic [8:0] bv,
                         input logic [15:0] eq, input logic [8:0] er, input logic edz);
    int n, bn;
    start_div(av, bv);
    wait_done(n, bn);
    check({tag, ".latency"}, n, 16);
    check({tag, ".busy_cycles"}, bn, 16);
    check({tag, ".out"}, out, eq);
    check({tag, ".rem"}, rem, er);
    check({tag, ".dz"}, dz, edz);
    step();
    check({tag, ".done_pulse"}, done, 0);
  endtask

  logic [15:0] q13;
  logic [15:0] qab;

  initial begin
    int n, bn, dcount;
    rst = 1'b1; start = 1'b0; a = 9'h000; b = 9'h000;
`ifdef BFDIV_ROUND_EN
    q13 = 16'h002B; qab = 16'h006B;
`else
    q13 = 16'h002A; qab = 16'h006A;
`endif
    step(); step();
    rst = 1'b0;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.out", out, 0);
    check("reset.rem", rem, 0);
    check("reset.dz", dz, 0);
    step();

    run_div("d100_100", 9'h100, 9'h100, 16'h0080, 9'h000, 1'b0);
    run_div("d1ff_001", 9'h1FF, 9'h001, 16'hFF80, 9'h000, 1'b0);
    run_div("d0ff_003", 9'h0FF, 9'h003, 16'h2A80, 9'h000, 1'b0);
    run_div("d001_003", 9'h001, 9'h003, q13,      9'h002, 1'b0);
    run_div("d1ff_1fe", 9'h1FF, 9'h1FE, 16'h0080, 9'h080, 1'b0);
    run_div("d0ab_0cd", 9'h0AB, 9'h0CD, qab,      9'h09E, 1'b0);
    run_div("dz_123",   9'h123, 9'h000, 16'hFFFF, 9'h000, 1'b1);
    run_div("d180_100", 9'h180, 9'h100, 16'h00C0, 9'h000, 1'b0);

    // Back-to-back: start held in DONE, plus a stray start pulse during RUN
    start_div(9'h0FF, 9'h003);
    wait_done(n, bn);
    check("b2b.first_latency", n, 16);
    check("b2b.first_out", out, 16'h2A80);
    start_div(9'h001, 9'h003);        // sampled in DONE
    check("b2b.busy_after_done", busy, 1);
    start = 1'b1;                     // ignored during RUN
    step();
    start = 1'b0;
    wait_done(n, bn);
    check("b2b.second_latency", n + 1, 16);
    check("b2b.second_out", out, q13);
    check("b2b.second_rem", rem, 9'h002);
    step();
    check("b2b.no_extra_done", done, 0);
    check("b2b.idle", busy, 0);

    // Reset in the middle of RUN
    start_div(9'h1FF, 9'h001);
    repeat (8) step();
    check("midrst.busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.out", out, 0);
    check("midrst.rem", rem, 0);
    dcount = 0;
    repeat (20) begin
      if (done) dcount++;
      step();
    end
    check("midrst.no_done", dcount, 0);
    run_div("after_rst", 9'h100, 9'h100, 16'h0080, 9'h000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
